// File: rtl/bullet_pool.sv
// Pool of NUM_BULLETS projectiles launched from the tank: lowest-free-slot launch,
// fire cooldown, shared step divider, playfield-edge and hit retirement.
module bullet_pool #(
    parameter int NUM_BULLETS = 4,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119,
    parameter int STEP_TICKS  = 656648,
    parameter int COOLDOWN    = 4000000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [XW-1:0]             tx,
    input  logic [YW-1:0]             ty,
    input  logic [1:0]                td,
    input  logic                      fire,
    input  logic [NUM_BULLETS-1:0]    hit,
    output logic [NUM_BULLETS*XW-1:0] bx,
    output logic [NUM_BULLETS*YW-1:0] by,
    output logic [NUM_BULLETS*3-1:0]  bd,
    output logic [NUM_BULLETS-1:0]    active,
    output logic                      fire_ack
);

    localparam int DW = $clog2(STEP_TICKS);
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic {S_WAIT, S_ARMED} state_t;

    state_t                 state;
    logic                   fire_p1;
    logic [CW-1:0]          cool;
    logic [DW-1:0]          div_cnt;
    logic                   tick_p1;
    logic                   ack;
    logic [NUM_BULLETS-1:0] act;
    logic [XW-1:0]          slot_x [NUM_BULLETS];
    logic [YW-1:0]          slot_y [NUM_BULLETS];
    logic [1:0]             slot_d [NUM_BULLETS];

    logic [NUM_BULLETS-1:0] sel;
    logic                   found;
    logic                   launch;

    function automatic logic [CW-1:0] cool_next(input logic [CW-1:0] c);
        return (c == '0) ? '0 : c - CW'(1);
    endfunction

    // True when the next step in direction d would leave the playfield.
    function automatic logic at_edge(input logic [1:0] d, input logic [XW-1:0] x,
                                     input logic [YW-1:0] y);
        case (d)
            2'd0:    return y == '0;
            2'd1:    return y == YW'(Y_MAX);
            2'd2:    return x == '0;
            default: return x == XW'(X_MAX);
        endcase
    endfunction

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!act[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        launch = (state == S_ARMED) && fire && !fire_p1 && (cool == '0) && found;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_WAIT;
            fire_p1 <= 1'b1;
            cool    <= '0;
            div_cnt <= '0;
            tick_p1 <= 1'b0;
            ack     <= 1'b0;
            act     <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
                slot_d[i] <= 2'd0;
            end
        end else begin
            fire_p1 <= fire;
            ack     <= launch;
            if (state == S_WAIT && start)
                state <= S_ARMED;
            cool <= launch ? CW'(COOLDOWN) : cool_next(cool);

            if (|act) begin
                if (div_cnt == DW'(STEP_TICKS - 1)) begin
                    div_cnt <= '0;
                    tick_p1 <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                    tick_p1 <= 1'b0;
                end
            end else begin
                div_cnt <= '0;
                tick_p1 <= 1'b0;
            end

            // Free slots shadow the tank so a launch loads the current position.
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (!act[i]) begin
                    slot_x[i] <= tx;
                    slot_y[i] <= ty;
                    if (launch && sel[i]) begin
                        slot_d[i] <= td;
                        act[i]    <= 1'b1;
                    end else begin
                        slot_d[i] <= 2'd0;
                    end
                end else if (hit[i]) begin
                    act[i]    <= 1'b0;
                    slot_d[i] <= 2'd0;
                end else if (tick_p1) begin
                    if (at_edge(slot_d[i], slot_x[i], slot_y[i])) begin
                        act[i]    <= 1'b0;
                        slot_d[i] <= 2'd0;
                    end else begin
                        case (slot_d[i])
                            2'd0:    slot_y[i] <= slot_y[i] - YW'(1);
                            2'd1:    slot_y[i] <= slot_y[i] + YW'(1);
                            2'd2:    slot_x[i] <= slot_x[i] - XW'(1);
                            default: slot_x[i] <= slot_x[i] + XW'(1);
                        endcase
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
        assign bx[g*XW +: XW] = slot_x[g];
        assign by[g*YW +: YW] = slot_y[g];
        assign bd[g*3 +: 3]   = {act[g], slot_d[g]};
    end

    assign active   = act;
    assign fire_ack = ack;

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them and every fire_ack pulse.
module tb_bullet_pool;

    localparam int NB = 2;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int SX = 0, SY = 1, SD = 2, SA = 3, SK = 4;

    logic              clk = 1'b0;
    logic              resetn, start, fire;
    logic [XW-1:0]     tx;
    logic [YW-1:0]     ty;
    logic [1:0]        td;
    logic [NB-1:0]     hit;
    logic [NB*XW-1:0]  bx;
    logic [NB*YW-1:0]  by;
    logic [NB*3-1:0]   bd;
    logic [NB-1:0]     active;
    logic              fire_ack;

    bullet_pool #(
        .NUM_BULLETS(NB), .XW(XW), .YW(YW), .X_MAX(159), .Y_MAX(119),
        .STEP_TICKS(4), .COOLDOWN(3)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .tx(tx), .ty(ty), .td(td),
        .fire(fire), .hit(hit), .bx(bx), .by(by), .bd(bd), .active(active),
        .fire_ack(fire_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    at;
        int    sig;
        int    idx;
        int    val;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];

    task automatic ex(input int at, input int sig, input int idx, input int val, input string name);
        exp_t e;
        e.at = at; e.sig = sig; e.idx = idx; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic at_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int actual(input int sig, input int idx);
        case (sig)
            SX:      return int'(bx[idx*XW +: XW]);
            SY:      return int'(by[idx*YW +: YW]);
            SD:      return int'(bd[idx*3 +: 3]);
            SA:      return int'(active);
            default: return int'(fire_ack);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at == cyc) begin
                int a;
                a = actual(exp_q[i].sig, exp_q[i].idx);
                checks++;
                if (a != exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                             exp_q[i].name, cyc, a, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
        if (ack_q.size() > 0 && ack_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL fire_ack_missing cyc=%0d actual=0 required=1 (due cyc %0d)", cyc, ack_q[0]);
            void'(ack_q.pop_front());
        end
        if (fire_ack === 1'b1) begin
            checks++;
            if (ack_q.size() > 0 && ack_q[0] == cyc) begin
                void'(ack_q.pop_front());
            end else begin
                errors++;
                $display("FAIL fire_ack_unexpected cyc=%0d actual=1 required=0", cyc);
            end
        end
    end

    initial begin
        resetn = 1'b0; start = 1'b0; fire = 1'b0;
        tx = 8'd10; ty = 7'd20; td = 2'd3; hit = '0;

        // Reset state
        at_cyc(2);
        ex(2, SA, 0, 0, "rst_active"); ex(2, SX, 0, 0, "rst_bx0"); ex(2, SY, 0, 0, "rst_by0");
        ex(2, SD, 0, 0, "rst_bd0");    ex(2, SX, 1, 0, "rst_bx1"); ex(2, SK, 0, 0, "rst_ack");
        resetn = 1'b1; start = 1'b1;

        // First launch, right, from (10,20)
        at_cyc(3);
        fire = 1'b1; start = 1'b0;
        ack_q.push_back(4);
        ex(4, SA, 0, 1, "launch0_active"); ex(4, SD, 0, 7, "launch0_bd0");
        ex(4, SX, 0, 10, "launch0_bx0");   ex(4, SY, 0, 20, "launch0_by0");
        ex(4, SX, 1, 10, "free_bx1");      ex(4, SD, 1, 0, "free_bd1");
        at_cyc(4); fire = 1'b0;
        ex(5, SY, 1, 20, "free_by1");
        at_cyc(5); fire = 1'b1;
        ex(6, SA, 0, 1, "cooldown_drop");
        at_cyc(6); fire = 1'b0;
        ex(8, SX, 0, 10, "pre_first_step_bx0");

        // Launch into slot1 on the same cycle as a tick
        at_cyc(8); fire = 1'b1; td = 2'd1;
        ack_q.push_back(9);
        ex(9, SA, 0, 3, "launch1_active");   ex(9, SX, 0, 11, "first_step_bx0");
        ex(9, SX, 1, 10, "tick_launch_bx1"); ex(9, SY, 1, 20, "tick_launch_by1");
        ex(9, SD, 1, 5, "launch1_bd1");
        at_cyc(9); fire = 1'b0;
        ex(12, SX, 0, 11, "hold_bx0"); ex(12, SY, 1, 20, "hold_by1");
        ex(13, SX, 0, 12, "second_step_bx0"); ex(13, SY, 1, 21, "first_step_by1");

        // Pool full: fire dropped
        at_cyc(13); fire = 1'b1;
        ex(14, SA, 0, 3, "full_drop_active"); ex(14, SD, 0, 7, "full_bd0");
        ex(14, SD, 1, 5, "full_bd1");         ex(14, SX, 0, 12, "full_hold_bx0");
        at_cyc(14); fire = 1'b0;

        // Hit slot0 while firing: retiring slot not yet selectable
        at_cyc(15); fire = 1'b1; hit = 2'b01;
        ex(16, SA, 0, 2, "hit0_retire"); ex(16, SD, 0, 0, "hit0_bd0");
        ex(16, SX, 0, 12, "hit0_hold_bx0");
        at_cyc(16); fire = 1'b0; hit = '0;
        ex(17, SY, 1, 22, "step_by1"); ex(17, SX, 0, 10, "track_bx0"); ex(17, SY, 0, 20, "track_by0");
        at_cyc(17); fire = 1'b1; td = 2'd2;
        ack_q.push_back(18);
        ex(18, SA, 0, 3, "relaunch0_active"); ex(18, SD, 0, 6, "relaunch0_bd0");
        ex(18, SX, 0, 10, "relaunch0_bx0");
        at_cyc(18); fire = 1'b0;
        ex(20, SY, 1, 22, "pre_tick_by1"); ex(20, SX, 0, 10, "pre_tick_bx0");

        // Hit slot1 on a tick cycle
        at_cyc(20); hit = 2'b10;
        ex(21, SA, 0, 1, "hit1_on_tick"); ex(21, SY, 1, 22, "hit1_no_step");
        ex(21, SD, 1, 0, "hit1_bd1");     ex(21, SX, 0, 9, "step_left_bx0");
        at_cyc(21); hit = '0;
        ex(22, SY, 1, 20, "track_by1"); ex(22, SX, 1, 10, "track_bx1");

        // Reset mid-flight with fire held through reset and start
        at_cyc(22); resetn = 1'b0; fire = 1'b1;
        ex(23, SA, 0, 0, "midrst_active"); ex(23, SX, 0, 0, "midrst_bx0");
        ex(23, SY, 0, 0, "midrst_by0");    ex(23, SD, 0, 0, "midrst_bd0");
        ex(23, SX, 1, 0, "midrst_bx1");    ex(23, SK, 0, 0, "midrst_ack");
        at_cyc(23); resetn = 1'b1; start = 1'b1;
        ex(26, SA, 0, 0, "held_fire_no_launch");
        at_cyc(26); fire = 1'b0; start = 1'b0;

        // Fire pulse in WAIT ignored
        at_cyc(27); resetn = 1'b0;
        at_cyc(28); resetn = 1'b1;
        at_cyc(29); fire = 1'b1;
        ex(30, SA, 0, 0, "wait_fire_ignored"); ex(31, SA, 0, 0, "wait_fire_ignored2");
        at_cyc(30); fire = 1'b0;
        at_cyc(31); start = 1'b1;

        // Upward bullet reaching the top edge
        at_cyc(32); start = 1'b0; tx = 8'd10; ty = 7'd1; td = 2'd0; fire = 1'b1;
        ack_q.push_back(33);
        ex(33, SA, 0, 1, "launch_up_active"); ex(33, SD, 0, 4, "launch_up_bd0");
        at_cyc(33); fire = 1'b0;
        ex(37, SY, 0, 1, "pre_tick_by0"); ex(38, SY, 0, 0, "up_to_zero");
        ex(38, SA, 0, 1, "up_still_active");
        at_cyc(39); tx = 8'd50; ty = 7'd60;
        ex(42, SA, 0, 0, "top_retire");   ex(42, SD, 0, 0, "top_retire_bd0");
        ex(42, SY, 0, 0, "top_retire_hold_by0");
        ex(43, SX, 0, 50, "retired_track_bx0"); ex(43, SY, 0, 60, "retired_track_by0");

        // Rightward bullet at X_MAX retires without wrapping
        at_cyc(43); tx = 8'd159; td = 2'd3; fire = 1'b1;
        ack_q.push_back(44);
        ex(44, SA, 0, 1, "launch_right_active"); ex(44, SX, 0, 159, "launch_right_bx0");
        at_cyc(44); fire = 1'b0; tx = 8'd20;
        ex(48, SX, 0, 159, "edge_pre_tick_bx0"); ex(48, SA, 0, 1, "edge_pre_tick_active");
        ex(49, SA, 0, 0, "right_edge_retire");   ex(49, SX, 0, 159, "no_wrap_bx0");
        ex(49, SD, 0, 0, "right_edge_bd0");      ex(50, SX, 0, 20, "post_retire_track_bx0");

        at_cyc(53);
        foreach (exp_q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s never_compared actual=none required=%0d", exp_q[i].name, exp_q[i].val);
        end
        foreach (ack_q[i]) begin
            checks++;
            errors++;
            $display("FAIL fire_ack_missing actual=0 required=1 (due cyc %0d)", ack_q[i]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
